// File: rtl/rollcall_loader_pkg.sv
// Shared definitions for the rollcall loader: state encoding, frame geometry, timer sizing.
package rollcall_loader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int SEATS  = 4;
   localparam int SEAT_W = 2;

   // Smallest width that can hold the value t (at least 1 bit).
   function automatic int tmr_w(input int t);
      return (t < 2) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/rollcall_loader_seat_reg.sv
// 2-bit seat/pattern register: load enable, synchronous clear, async active-low reset.
module rollcall_loader_seat_reg
   import rollcall_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              ld,
   input  logic [SEAT_W-1:0] d,
   output logic [SEAT_W-1:0] q
);

   // Clear has priority so a new frame always starts from an all-zero seat set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   q <= '0;
      else if (clr) q <= '0;
      else if (ld)  q <= d;
   end

endmodule

// File: rtl/rollcall_loader.sv
// Rollcall loader: assembles four serial seat codes into a held frame for the matcher.
module rollcall_loader
   import rollcall_loader_pkg::*;
#(
   parameter int ACK_TIMEOUT = 15
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  pat_in,
   input  logic        mode_in,
   input  logic        in_valid,
   input  logic [1:0]  in_data,
   output logic        in_ready,
   output logic [1:0]  s0,
   output logic [1:0]  s1,
   output logic [1:0]  s2,
   output logic [1:0]  s3,
   output logic [1:0]  pat,
   output logic        mode,
   output logic        frame_valid,
   input  logic        frame_ack,
   output logic [2:0]  fill_cnt,
   output logic [3:0]  frame_cnt,
   output logic        timeout
);

   localparam int TW = tmr_w(ACK_TIMEOUT);

   state_t                         state;
   logic [TW-1:0]                  timer;
   logic [SEATS-1:0][SEAT_W-1:0]   seat;
   logic [SEATS-1:0]               seat_ld;
   logic                           frame_start;
   logic                           xfer;

   assign in_ready    = (state == FILL);
   assign frame_valid = (state == HOLD);
   assign frame_start = (state == IDLE) && start;
   assign xfer        = in_valid && in_ready;

   // One register per seat; the k-th accepted code lands in seat k.
   for (genvar k = 0; k < SEATS; k++) begin : g_seat
      assign seat_ld[k] = xfer && (fill_cnt == 3'(k));
      rollcall_loader_seat_reg u_seat (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (frame_start),
         .ld    (seat_ld[k]),
         .d     (in_data),
         .q     (seat[k])
      );
   end

   // Pattern shares the seat register; loaded rather than cleared on START.
   rollcall_loader_seat_reg u_pat (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .ld    (frame_start),
      .d     (pat_in),
      .q     (pat)
   );

   assign s0 = seat[0];
   assign s1 = seat[1];
   assign s2 = seat[2];
   assign s3 = seat[3];

   // Frame FSM: IDLE -> FILL (4 transfers) -> HOLD (until ACK or timeout) -> IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         mode      <= 1'b0;
         fill_cnt  <= '0;
         frame_cnt <= '0;
         timeout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mode     <= mode_in;
                  fill_cnt <= '0;
                  timeout  <= 1'b0;
                  state    <= FILL;
               end
            end
            FILL: begin
               if (in_valid) begin
                  fill_cnt <= fill_cnt + 3'd1;
                  if (fill_cnt == 3'(SEATS - 1)) begin
                     state <= HOLD;
                     timer <= '0;
                  end
               end
            end
            HOLD: begin
               // ACK wins over a simultaneous expiry.
               if (frame_ack) begin
                  frame_cnt <= frame_cnt + 4'd1;
                  state     <= IDLE;
               end else if (ACK_TIMEOUT != 0 && timer == TW'(ACK_TIMEOUT - 1)) begin
                  timeout <= 1'b1;
                  state   <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/rollcall_loader.md
Name: rollcall_loader

Overview:
- Upstream feeder for the combinational rollcall matcher.
- Accepts a serial stream of 2-bit seat codes over a valid/ready handshake and assembles them into a 4-seat frame on S0..S3.
- Latches the pattern and mode with the frame and holds the complete frame stable with FRAME_VALID until the consumer acknowledges it.
- Recovers with a sticky timeout flag if the consumer never acknowledges.

Parameters:
- ACK_TIMEOUT, 15: cycles spent in HOLD without FRAME_ACK before the frame is abandoned. 0 disables the timeout.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- START  input  1  begin a new frame; honoured only in IDLE.
- PAT_IN  input  2  pattern, latched on an accepted START.
- MODE_IN  input  1  mode, latched on an accepted START.
- IN_VALID  input  1  IN_DATA holds a seat code.
- IN_DATA  input  2  seat code.
- IN_READY  output  1  loader accepts a seat code this cycle.
- S0, S1, S2, S3  output  2 each  assembled seat codes, registered.
- PAT  output  2  latched pattern, registered.
- MODE  output  1  latched mode, registered.
- FRAME_VALID  output  1  complete frame presented on S0..S3/PAT/MODE.
- FRAME_ACK  input  1  consumer has taken the frame.
- FILL_CNT  output  3  seats accepted in the current frame (0..4).
- FRAME_CNT  output  4  frames acknowledged since reset; wraps 15->0.
- TIMEOUT  output  1  sticky: last frame was abandoned.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state IDLE.
  - S0..S3, PAT, MODE, FILL_CNT, FRAME_CNT, TIMEOUT, FRAME_VALID all 0; IN_READY 0.
  - Reset mid-frame discards all partial data.
- State encoding: IDLE, FILL, HOLD. IN_READY = (state==FILL), combinational from state only. FRAME_VALID = (state==HOLD), registered state bit.
- IDLE:
  - START=1 -> next edge: PAT<=PAT_IN, MODE<=MODE_IN, S0..S3<=0, FILL_CNT<=0, TIMEOUT<=0, state<=FILL.
  - IN_VALID and FRAME_ACK are ignored.
- FILL:
  - A seat transfer occurs on any edge with IN_VALID & IN_READY. The k-th accepted code (k=0..3) is written to Sk, and FILL_CNT increments.
  - IN_VALID low: no change, no timeout in FILL.
  - On the 4th transfer -> FILL_CNT=4, state<=HOLD on that same edge, so FRAME_VALID rises 1 cycle after the last accept.
  - START in FILL is ignored; PAT/MODE are unchanged.
- HOLD:
  - S0..S3, PAT, MODE stable; IN_READY 0; hold timer counts cycles in HOLD, starting at 0 on entry.
  - FRAME_ACK=1 -> next edge: state<=IDLE, FRAME_CNT<=FRAME_CNT+1 (mod 16). S0..S3/PAT/MODE keep their values until the next START.
  - Timer reaches ACK_TIMEOUT with no ACK -> next edge: state<=IDLE, TIMEOUT<=1, FRAME_CNT unchanged.
  - FRAME_ACK on the same cycle the timer expires: ACK wins, TIMEOUT stays 0.
  - START in HOLD is ignored.
- Minimum frame time: 1 (START) + 4 (fill) + 1 (ACK) = 6 cycles, then back in IDLE.
- Timer width is the smallest width holding ACK_TIMEOUT. FILL_CNT never exceeds 4.

Decomposition:
- Shared include file holds:
  - state encodings IDLE=2'd0, FILL=2'd1, HOLD=2'd2;
  - localparam SEATS=4;
  - localparam SEAT_W=2.
- One natural sub-module: seat_reg, a 2-bit register with load enable, synchronous clear, async active-low reset. Instantiated four times, plus once for PAT.

Test Plan:
- Basic frame: reset, START with PAT_IN=2'b10, MODE_IN=1; stream 01,11,00,10 with IN_VALID held high.
  - FRAME_VALID rises on the cycle after the 4th accept.
  - Outputs: S0=01, S1=11, S2=00, S3=10, PAT=10, MODE=1, FILL_CNT=4.
  - ACK -> FRAME_CNT=1, IDLE.
- Gapped input: same codes with IN_VALID low for 3 cycles between codes 2 and 3.
  - FILL_CNT holds at 2 during the gap; final frame identical to the basic case.
  - START pulsed during the gap is ignored (PAT unchanged).
- Timeout: complete a frame, never ACK, ACK_TIMEOUT=15.
  - Exactly 15 HOLD cycles later FRAME_VALID falls and TIMEOUT=1; FRAME_CNT unchanged.
  - Next START clears TIMEOUT.
- ACK/timeout collision: assert FRAME_ACK on the expiry cycle.
  - IDLE, TIMEOUT=0, FRAME_CNT increments.
- Wrap and reset: complete 16 acknowledged frames.
  - FRAME_CNT goes 15->0.
  - Assert RST_N low asynchronously mid-FILL after 2 codes: all outputs 0 immediately, IN_READY 0, state IDLE.
